// File: rtl/adc_deser_avg_block.sv
// Multi-channel dual-lane ADC deserialiser with optional box-car averaging.
// Frames start on frame_start; results are packed signed words with a valid strobe.
module adc_deser_avg_block #(
  parameter int ADC_CHANNELS   = 4,
  parameter int ADC_DATA_WIDTH = 18,
  parameter int AVG_LOG2       = 0
) (
  input  logic                                   adc_read_clk,
  input  logic                                   rst_n,
  input  logic                                   reader_en_sync,
  input  logic                                   frame_start,
  input  logic [ADC_CHANNELS-1:0]                adc_sdo_cha,
  input  logic [ADC_CHANNELS-1:0]                adc_sdo_chb,
  input  logic                                   overrun_clr,
  output logic [ADC_DATA_WIDTH*ADC_CHANNELS-1:0] adc_a_data_arr,
  output logic [ADC_DATA_WIDTH*ADC_CHANNELS-1:0] adc_b_data_arr,
  output logic                                   data_valid,
  output logic                                   busy,
  output logic [31:0]                            sample_cnt,
  output logic                                   overrun
);

  localparam int AW = ADC_DATA_WIDTH + AVG_LOG2;
  localparam int GW = AVG_LOG2 + 1;
  localparam int BW = $clog2(ADC_DATA_WIDTH);
  localparam logic [GW-1:0] GROUP_LEN = GW'(1 << AVG_LOG2);
  localparam logic [BW-1:0] LAST_BIT  = BW'(ADC_DATA_WIDTH - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, LATCH} state_t;

  state_t                      state;
  logic [BW-1:0]               bit_cnt;
  logic [GW-1:0]               grp_cnt;
  logic [GW-1:0]               grp_nxt;
  logic                        group_done;
  logic signed [ADC_DATA_WIDTH-1:0] sh_a [ADC_CHANNELS];
  logic signed [ADC_DATA_WIDTH-1:0] sh_b [ADC_CHANNELS];
  logic signed [AW-1:0]        acc_a [ADC_CHANNELS];
  logic signed [AW-1:0]        acc_b [ADC_CHANNELS];
  logic signed [AW-1:0]        acc_a_nxt [ADC_CHANNELS];
  logic signed [AW-1:0]        acc_b_nxt [ADC_CHANNELS];

  assign busy = (state != IDLE);

  always_comb begin
    grp_nxt    = grp_cnt + GW'(1);
    group_done = (grp_nxt == GROUP_LEN);
    for (int k = 0; k < ADC_CHANNELS; k++) begin
      acc_a_nxt[k] = acc_a[k] + AW'(sh_a[k]);
      acc_b_nxt[k] = acc_b[k] + AW'(sh_b[k]);
    end
  end

  always_ff @(posedge adc_read_clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      bit_cnt        <= '0;
      grp_cnt        <= '0;
      data_valid     <= 1'b0;
      sample_cnt     <= '0;
      overrun        <= 1'b0;
      adc_a_data_arr <= '0;
      adc_b_data_arr <= '0;
      for (int k = 0; k < ADC_CHANNELS; k++) begin
        sh_a[k]  <= '0;
        sh_b[k]  <= '0;
        acc_a[k] <= '0;
        acc_b[k] <= '0;
      end
    end else begin
      data_valid <= 1'b0;
      // Set has priority over clear so a coincident overrun is never lost
      if (frame_start && state != IDLE)
        overrun <= 1'b1;
      else if (overrun_clr)
        overrun <= 1'b0;

      if (state != IDLE && !reader_en_sync) begin
        state   <= IDLE;
        bit_cnt <= '0;
        grp_cnt <= '0;
        for (int k = 0; k < ADC_CHANNELS; k++) begin
          sh_a[k]  <= '0;
          sh_b[k]  <= '0;
          acc_a[k] <= '0;
          acc_b[k] <= '0;
        end
      end else begin
        case (state)
          IDLE: begin
            if (frame_start && reader_en_sync) begin
              state   <= SHIFT;
              bit_cnt <= '0;
            end
          end
          SHIFT: begin
            for (int k = 0; k < ADC_CHANNELS; k++) begin
              sh_a[k] <= {sh_a[k][ADC_DATA_WIDTH-2:0], adc_sdo_cha[k]};
              sh_b[k] <= {sh_b[k][ADC_DATA_WIDTH-2:0], adc_sdo_chb[k]};
            end
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == LAST_BIT)
              state <= LATCH;
          end
          LATCH: begin
            state <= IDLE;
            // Arithmetic shift floors toward -inf; the sum cannot overflow AW bits
            if (group_done) begin
              for (int k = 0; k < ADC_CHANNELS; k++) begin
                adc_a_data_arr[ADC_DATA_WIDTH*k +: ADC_DATA_WIDTH] <= ADC_DATA_WIDTH'(acc_a_nxt[k] >>> AVG_LOG2);
                adc_b_data_arr[ADC_DATA_WIDTH*k +: ADC_DATA_WIDTH] <= ADC_DATA_WIDTH'(acc_b_nxt[k] >>> AVG_LOG2);
                acc_a[k] <= '0;
                acc_b[k] <= '0;
              end
              grp_cnt    <= '0;
              data_valid <= 1'b1;
              sample_cnt <= sample_cnt + 32'd1;
            end else begin
              for (int k = 0; k < ADC_CHANNELS; k++) begin
                acc_a[k] <= acc_a_nxt[k];
                acc_b[k] <= acc_b_nxt[k];
              end
              grp_cnt <= grp_nxt;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_adc_deser_avg_block.sv
// Directed bench for adc_deser_avg_block: three instances cover AVG_LOG2 = 0, 1 and 2.
// Each instance has its own frame_start; serial data, enable, clear and reset are shared.
module tb_adc_deser_avg_block;

  logic        clock = 1'b0;
  logic        rst_n = 1'b0;
  logic        reader_en_sync = 1'b1;
  logic [2:0]  frame_start = '0;
  logic [3:0]  sdo_a = '0;
  logic [3:0]  sdo_b = '0;
  logic        overrun_clr = 1'b0;

  logic [71:0] a_arr [3];
  logic [71:0] b_arr [3];
  logic [2:0]  data_valid;
  logic [2:0]  busy;
  logic [31:0] sample_cnt [3];
  logic [2:0]  overrun;

  int tests_run = 0;
  int tests_failed = 0;
  int dv_count;
  int dv_cycle;
  logic busy_log [22];

  always #5 clock = ~clock;

  adc_deser_avg_block #(.ADC_CHANNELS(4), .ADC_DATA_WIDTH(18), .AVG_LOG2(0)) dut0 (
    .adc_read_clk(clock), .rst_n(rst_n), .reader_en_sync(reader_en_sync),
    .frame_start(frame_start[0]), .adc_sdo_cha(sdo_a), .adc_sdo_chb(sdo_b),
    .overrun_clr(overrun_clr), .adc_a_data_arr(a_arr[0]), .adc_b_data_arr(b_arr[0]),
    .data_valid(data_valid[0]), .busy(busy[0]), .sample_cnt(sample_cnt[0]), .overrun(overrun[0]));

  adc_deser_avg_block #(.ADC_CHANNELS(4), .ADC_DATA_WIDTH(18), .AVG_LOG2(1)) dut1 (
    .adc_read_clk(clock), .rst_n(rst_n), .reader_en_sync(reader_en_sync),
    .frame_start(frame_start[1]), .adc_sdo_cha(sdo_a), .adc_sdo_chb(sdo_b),
    .overrun_clr(overrun_clr), .adc_a_data_arr(a_arr[1]), .adc_b_data_arr(b_arr[1]),
    .data_valid(data_valid[1]), .busy(busy[1]), .sample_cnt(sample_cnt[1]), .overrun(overrun[1]));

  adc_deser_avg_block #(.ADC_CHANNELS(4), .ADC_DATA_WIDTH(18), .AVG_LOG2(2)) dut2 (
    .adc_read_clk(clock), .rst_n(rst_n), .reader_en_sync(reader_en_sync),
    .frame_start(frame_start[2]), .adc_sdo_cha(sdo_a), .adc_sdo_chb(sdo_b),
    .overrun_clr(overrun_clr), .adc_a_data_arr(a_arr[2]), .adc_b_data_arr(b_arr[2]),
    .data_valid(data_valid[2]), .busy(busy[2]), .sample_cnt(sample_cnt[2]), .overrun(overrun[2]));

  task automatic checkOutput(input string tag, input logic [71:0] got, input logic [71:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Position p is the negedge before posedge p; outputs read there are the cycle-p values.
  task automatic applyStimulus(input int sel, input logic [71:0] a_words, input logic [71:0] b_words,
                               input int extra_at, input int drop_at, input int clr_at, input int rst_at);
    dv_count = 0;
    dv_cycle = -1;
    for (int p = 0; p < 22; p++) begin
      @(negedge clock);
      busy_log[p] = busy[sel];
      if (data_valid[sel]) begin
        dv_count++;
        dv_cycle = p;
      end
      frame_start      = '0;
      frame_start[sel] = (p == 0 || p == extra_at);
      reader_en_sync   = !(drop_at > 0 && p >= drop_at);
      overrun_clr      = (p == clr_at);
      for (int k = 0; k < 4; k++) begin
        sdo_a[k] = (p >= 1 && p <= 18) ? a_words[18*k + 18 - p] : 1'b0;
        sdo_b[k] = (p >= 1 && p <= 18) ? b_words[18*k + 18 - p] : 1'b0;
      end
      if (p == rst_at) begin
        rst_n = 1'b0;
        #1;
        checkOutput("rst_busy", 72'(busy[sel]), 72'd0);
        checkOutput("rst_a_arr", a_arr[sel], 72'd0);
        checkOutput("rst_b_arr", b_arr[sel], 72'd0);
        checkOutput("rst_cnt", 72'(sample_cnt[sel]), 72'd0);
        checkOutput("rst_overrun", 72'(overrun[sel]), 72'd0);
        checkOutput("rst_dv", 72'(data_valid[sel]), 72'd0);
      end
    end
    @(negedge clock);
    frame_start    = '0;
    reader_en_sync = 1'b1;
    overrun_clr    = 1'b0;
    rst_n          = 1'b1;
  endtask

  initial begin
    repeat (3) @(negedge clock);
    rst_n = 1'b1;
    @(negedge clock);
    checkOutput("init_a", a_arr[0], 72'd0);
    checkOutput("init_cnt", 72'(sample_cnt[0]), 72'd0);
    checkOutput("init_flags", 72'({data_valid[0], busy[0], overrun[0]}), 72'd0);

    // Raw single frame on the non-averaging instance
    applyStimulus(0, 72'h2AAAA, 72'h15555, -1, 0, -1, -1);
    checkOutput("raw_dv_count", 72'(dv_count), 72'd1);
    checkOutput("raw_dv_cycle", 72'(dv_cycle), 72'd20);
    checkOutput("raw_busy_c1", 72'(busy_log[1]), 72'd1);
    checkOutput("raw_busy_c19", 72'(busy_log[19]), 72'd1);
    checkOutput("raw_busy_c20", 72'(busy_log[20]), 72'd0);
    checkOutput("raw_a", a_arr[0], 72'h2AAAA);
    checkOutput("raw_b", b_arr[0], 72'h15555);
    checkOutput("raw_cnt", 72'(sample_cnt[0]), 72'd1);

    // Average of four: A ch3 100..103 -> 101, B ch1 -5 x4 -> -5
    for (int i = 0; i < 4; i++) begin
      applyStimulus(2, 72'(100 + i) << 54, 72'h3FFFB << 18, -1, 0, -1, -1);
      checkOutput($sformatf("avg4_f%0d_dv", i), 72'(dv_count), (i == 3) ? 72'd1 : 72'd0);
    end
    checkOutput("avg4_a", a_arr[2], 72'd101 << 54);
    checkOutput("avg4_b", b_arr[2], 72'h3FFFB << 18);
    checkOutput("avg4_cnt", 72'(sample_cnt[2]), 72'd1);

    // Average of two negatives: (-1 + -2) / 2 floors to -2
    applyStimulus(1, 72'h3FFFF, 72'h0, -1, 0, -1, -1);
    checkOutput("avg2_f0_dv", 72'(dv_count), 72'd0);
    applyStimulus(1, 72'h3FFFE, 72'h0, -1, 0, -1, -1);
    checkOutput("avg2_f1_dv", 72'(dv_count), 72'd1);
    checkOutput("avg2_a", a_arr[1], 72'h3FFFE);

    // Second frame_start at cycle 5 is an overrun; frame 0 still completes
    applyStimulus(0, 72'h1234 << 36, 72'h0, 5, 0, -1, -1);
    checkOutput("ovr_flag", 72'(overrun[0]), 72'd1);
    checkOutput("ovr_dv_cycle", 72'(dv_cycle), 72'd20);
    checkOutput("ovr_dv_count", 72'(dv_count), 72'd1);
    checkOutput("ovr_a", a_arr[0], 72'h1234 << 36);
    checkOutput("ovr_cnt", 72'(sample_cnt[0]), 72'd2);
    overrun_clr = 1'b1;
    @(negedge clock);
    overrun_clr = 1'b0;
    checkOutput("ovr_cleared", 72'(overrun[0]), 72'd0);

    // frame_start with enable low is ignored and raises no overrun
    reader_en_sync = 1'b0;
    frame_start[0] = 1'b1;
    @(negedge clock);
    frame_start[0] = 1'b0;
    @(negedge clock);
    checkOutput("en0_busy", 72'(busy[0]), 72'd0);
    checkOutput("en0_overrun", 72'(overrun[0]), 72'd0);
    reader_en_sync = 1'b1;

    // Clear coinciding with a new overrun: the set wins
    applyStimulus(0, 72'h1234 << 36, 72'h0, 5, 0, 5, -1);
    checkOutput("ovr_set_wins", 72'(overrun[0]), 72'd1);
    checkOutput("ovr2_cnt", 72'(sample_cnt[0]), 72'd3);

    // Enable dropped at cycle 10 aborts the frame
    applyStimulus(0, 72'h3FFFF << 18, 72'h3FFFF, -1, 10, -1, -1);
    checkOutput("abort_busy_c10", 72'(busy_log[10]), 72'd1);
    checkOutput("abort_busy_c11", 72'(busy_log[11]), 72'd0);
    checkOutput("abort_dv", 72'(dv_count), 72'd0);
    checkOutput("abort_a_kept", a_arr[0], 72'h1234 << 36);
    checkOutput("abort_cnt_kept", 72'(sample_cnt[0]), 72'd3);
    applyStimulus(0, 72'h5 << 18, 72'h0, -1, 0, -1, -1);
    checkOutput("post_abort_a", a_arr[0], 72'h5 << 18);
    checkOutput("post_abort_b", b_arr[0], 72'd0);
    checkOutput("post_abort_cnt", 72'(sample_cnt[0]), 72'd4);

    // Abort must discard a half-filled group: 10 then aborted 20, then 4, 6 -> 5
    applyStimulus(1, 72'd10, 72'h0, -1, 0, -1, -1);
    applyStimulus(1, 72'd20, 72'h0, -1, 10, -1, -1);
    applyStimulus(1, 72'd4, 72'h0, -1, 0, -1, -1);
    checkOutput("grp_clr_no_dv", 72'(dv_count), 72'd0);
    applyStimulus(1, 72'd6, 72'h0, -1, 0, -1, -1);
    checkOutput("grp_clr_dv", 72'(dv_count), 72'd1);
    checkOutput("grp_clr_a", a_arr[1], 72'd5);

    // Asynchronous reset at cycle 8 of a frame, then a clean frame
    applyStimulus(0, 72'h3FFFF, 72'h3FFFF, -1, 0, -1, 8);
    checkOutput("rst_frame_dv", 72'(dv_count), 72'd0);
    applyStimulus(0, 72'h20000, 72'h1FFFF << 54, -1, 0, -1, -1);
    checkOutput("after_rst_dv_cycle", 72'(dv_cycle), 72'd20);
    checkOutput("after_rst_a", a_arr[0], 72'h20000);
    checkOutput("after_rst_b", b_arr[0], 72'h1FFFF << 54);
    checkOutput("after_rst_cnt", 72'(sample_cnt[0]), 72'd1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
